// File: rtl/riscv_pkg.sv
// Shared types for the RV32I pipeline: forwarding selects, multi-cycle FSM states
// and result-source encodings.
package riscv_pkg;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        MC_IDLE,
        MC_BUSY,
        MC_DONE
    } mc_state_e;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    // A pending write to a non-zero register that matches a source operand.
    function automatic logic reg_hit(input logic we, input logic [4:0] rd, input logic [4:0] rs);
        return we && (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/fwd_unit.sv
// EX-stage forwarding select for a single source operand; MEM beats WB, x0 never forwards.
module fwd_unit
    import riscv_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] rd_mem,
    input  logic [4:0] rd_wb,
    input  logic       we_mem,
    input  logic       we_wb,
    output logic [1:0] sel
);

    fwd_sel_e sel_e;

    always_comb begin
        sel_e = FWD_NONE;
        if (reg_hit(we_mem, rd_mem, rs)) begin
            sel_e = FWD_MEM;
        end else if (reg_hit(we_wb, rd_wb, rs)) begin
            sel_e = FWD_WB;
        end
    end

    assign sel = sel_e;

endmodule

// File: rtl/hazard_ctrl.sv
// Central hazard controller: forwarding, load-use stalls, branch flushes and
// sequencing of the iterative multi-cycle EX unit with a timeout watchdog.
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int MC_TIMEOUT = 64,
    parameter int PERF_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        Rs1D,
    input  logic [4:0]        Rs2D,
    input  logic [4:0]        Rs1E,
    input  logic [4:0]        Rs2E,
    input  logic [4:0]        RdE,
    input  logic [4:0]        RdM,
    input  logic [4:0]        RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic [1:0]        ResultSrcE,
    input  logic              PCSrcE,
    input  logic              MultiCycleE,
    input  logic              McDone,
    output logic              McStart,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              BubbleM,
    output logic              McError,
    output logic [PERF_W-1:0] StallCount
);

    localparam int CW = 10;

    mc_state_e     state;
    logic [CW-1:0] cnt;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic          lw_stall;
    logic          mc_stall;

    fwd_unit u_fwd_a (
        .rs     (Rs1E),
        .rd_mem (RdM),
        .rd_wb  (RdW),
        .we_mem (RegWriteM),
        .we_wb  (RegWriteW),
        .sel    (fwd_a)
    );

    fwd_unit u_fwd_b (
        .rs     (Rs2E),
        .rd_mem (RdM),
        .rd_wb  (RdW),
        .we_mem (RegWriteM),
        .we_wb  (RegWriteW),
        .sel    (fwd_b)
    );

    assign lw_stall = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != 5'd0) &&
                      ((RdE == Rs1D) || (RdE == Rs2D));
    assign mc_stall = ((state == MC_IDLE) && MultiCycleE) || (state == MC_BUSY);

    // Every combinational output is forced low while reset is asserted.
    always_comb begin
        McStart   = 1'b0;
        ForwardAE = FWD_NONE;
        ForwardBE = FWD_NONE;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        BubbleM   = 1'b0;
        if (!rst) begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            if (mc_stall) begin
                McStart = (state == MC_IDLE);
                StallF  = 1'b1;
                StallD  = 1'b1;
                StallE  = 1'b1;
                BubbleM = 1'b1;
            end else begin
                StallF = lw_stall;
                StallD = lw_stall;
                FlushD = PCSrcE;
                FlushE = lw_stall || PCSrcE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= MC_IDLE;
            cnt        <= '0;
            McError    <= 1'b0;
            StallCount <= '0;
        end else begin
            case (state)
                MC_IDLE: begin
                    if (MultiCycleE) begin
                        cnt   <= CW'(1);
                        state <= MC_BUSY;
                    end
                end
                MC_BUSY: begin
                    // A completion on the timeout cycle wins over the watchdog.
                    if (McDone) begin
                        state <= MC_DONE;
                    end else if (cnt == CW'(MC_TIMEOUT)) begin
                        McError <= 1'b1;
                        state   <= MC_DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                MC_DONE: state <= MC_IDLE;
                default: state <= MC_IDLE;
            endcase
            if (StallF && (StallCount != '1)) begin
                StallCount <= StallCount + PERF_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl against a cycle-schedule reference model.
module tb_hazard_ctrl;

    localparam int TO  = 8;
    localparam int PW  = 4;
    localparam int SAT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic          RegWriteM, RegWriteW;
    logic [1:0]    ResultSrcE;
    logic          PCSrcE, MultiCycleE, McDone;
    logic          McStart;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, FlushD, FlushE, BubbleM, McError;
    logic [PW-1:0] StallCount;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_count = 0;
    logic exp_err   = 1'b0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MC_TIMEOUT(TO), .PERF_W(PW)) dut (
        .clk(clk), .rst(rst),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .MultiCycleE(MultiCycleE),
        .McDone(McDone), .McStart(McStart), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD),
        .FlushE(FlushE), .BubbleM(BubbleM), .McError(McError), .StallCount(StallCount)
    );

    wire [10:0] outv = {McStart, ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, BubbleM};

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic ref_lw();
        return ResultSrcE == 2'b01 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
    endfunction

    function automatic logic [10:0] ref_pipe();
        logic lw;
        lw = ref_lw();
        return {1'b0, ref_fwd(Rs1E), ref_fwd(Rs2E), lw, lw, 1'b0, PCSrcE, lw | PCSrcE, 1'b0};
    endfunction

    function automatic logic [10:0] ref_mc(input logic start);
        return {start, ref_fwd(Rs1E), ref_fwd(Rs2E), 6'b111001};
    endfunction

    task automatic rand_regs();
        Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
        Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
        RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
        RdW  = 5'($urandom_range(0, 3));
        RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
    endtask

    task automatic quiet();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0; MultiCycleE = 0; McDone = 0;
    endtask

    task automatic tick(input logic stalled);
        @(posedge clk);
        #1;
        if (stalled && exp_count < SAT) exp_count++;
    endtask

    task automatic test_reset();
        rst = 1; rand_regs(); ResultSrcE = 2'b01; PCSrcE = 1; MultiCycleE = 1; McDone = 1;
        @(negedge clk);
        n_checks++;
        if (outv !== 11'd0) begin n_fail++; $display("FAIL reset_outputs got=%b want=%b", outv, 11'd0); end
        tick(1'b0);
        n_checks++;
        if ({McError, StallCount} !== '0) begin
            n_fail++; $display("FAIL reset_regs McError=%b StallCount=%0d want 0/0", McError, StallCount);
        end
        exp_count = 0; exp_err = 0; rst = 0; quiet();
    endtask

    task automatic test_load_use();
        int c0;
        quiet(); ResultSrcE = 2'b01; RdE = 7; Rs2D = 7; Rs1D = 3;
        c0 = exp_count;
        @(negedge clk);
        n_checks++;
        if ({StallF, StallD, FlushE, StallE, McStart} !== 5'b11100) begin
            n_fail++; $display("FAIL load_use_stall got=%b want=11100", {StallF, StallD, FlushE, StallE, McStart});
        end
        tick(1'b1);
        n_checks++;
        if (StallCount !== PW'(c0 + 1)) begin
            n_fail++; $display("FAIL load_use_count got=%0d want=%0d", StallCount, c0 + 1);
        end
        ResultSrcE = 2'b00;
        @(negedge clk);
        n_checks++;
        if ({StallF, StallD, FlushE} !== 3'b000) begin
            n_fail++; $display("FAIL load_use_release got=%b want=000", {StallF, StallD, FlushE});
        end
        tick(1'b0);
    endtask

    task automatic test_branch();
        quiet(); PCSrcE = 1;
        @(negedge clk);
        n_checks++;
        if ({FlushD, FlushE, StallF, StallD, StallE, McStart, BubbleM} !== 7'b1100000) begin
            n_fail++;
            $display("FAIL branch_flush got=%b want=1100000", {FlushD, FlushE, StallF, StallD, StallE, McStart, BubbleM});
        end
        tick(1'b0);
        quiet();
    endtask

    task automatic test_forwarding();
        logic [1:0] want [3] = '{2'b10, 2'b01, 2'b00};
        for (int i = 0; i < 3; i++) begin
            quiet(); RdM = 5; RdW = 5; Rs1E = 5; Rs2E = 5; RegWriteM = 1; RegWriteW = 1;
            if (i == 1) RegWriteM = 0;
            if (i == 2) begin Rs1E = 0; Rs2E = 0; RdM = 0; RdW = 0; end
            @(negedge clk);
            n_checks++;
            if ({ForwardAE, ForwardBE} !== {want[i], want[i]}) begin
                n_fail++; $display("FAIL fwd_prio_%0d got=%b/%b want=%b", i, ForwardAE, ForwardBE, want[i]);
            end
            tick(1'b0);
        end
        quiet();
    endtask

    task automatic test_random_pipe(input int cycles);
        logic [10:0] e;
        for (int i = 0; i < cycles; i++) begin
            rand_regs();
            ResultSrcE = 2'($urandom_range(0, 3)); PCSrcE = 1'($urandom_range(0, 1));
            MultiCycleE = 0; McDone = 1'($urandom_range(0, 1));
            @(negedge clk);
            e = ref_pipe();
            n_checks++;
            if (outv !== e) begin n_fail++; $display("FAIL rand_pipe[%0d] got=%b want=%b", i, outv, e); end
            tick(e[5]);
            n_checks++;
            if (StallCount !== PW'(exp_count)) begin
                n_fail++; $display("FAIL rand_pipe_count[%0d] got=%0d want=%0d", i, StallCount, exp_count);
            end
        end
        quiet();
    endtask

    // n: cycles from McStart to McDone; done=0 means the unit never answers.
    task automatic test_multicycle(input int n, input logic done);
        logic        timeout;
        int          last;
        logic [10:0] e;
        timeout = !(done && n <= TO);
        last    = timeout ? TO : n;
        for (int c = 0; c <= last + 1; c++) begin
            rand_regs(); ResultSrcE = 0; PCSrcE = 0; MultiCycleE = 1;
            if (c == last + 1) McDone = 1'($urandom_range(0, 1));
            else McDone = done && (c == n);
            @(negedge clk);
            e = (c <= last) ? ref_mc(c == 0) : ref_pipe();
            n_checks++;
            if (outv !== e) begin n_fail++; $display("FAIL mc_n%0d_c%0d got=%b want=%b", n, c, outv, e); end
            tick(c <= last);
            if (timeout && c == last) exp_err = 1;
            n_checks++;
            if ({McError, StallCount} !== {exp_err, PW'(exp_count)}) begin
                n_fail++; $display("FAIL mc_regs_n%0d_c%0d got=%b/%0d want=%b/%0d",
                                   n, c, McError, StallCount, exp_err, exp_count);
            end
        end
        quiet(); McDone = 1'($urandom_range(0, 1));
        @(negedge clk);
        n_checks++;
        if (outv !== ref_pipe()) begin n_fail++; $display("FAIL mc_idle_after got=%b want=%b", outv, ref_pipe()); end
        tick(1'b0);
        quiet();
    endtask

    task automatic test_reset_mid_busy();
        for (int c = 0; c < 3; c++) begin
            quiet(); MultiCycleE = 1;
            @(negedge clk);
            tick(1'b1);
        end
        rst = 1; rand_regs(); ResultSrcE = 2'b01; PCSrcE = 1;
        @(negedge clk);
        n_checks++;
        if (outv !== 11'd0) begin n_fail++; $display("FAIL rst_busy_outputs got=%b want=0", outv); end
        tick(1'b0);
        exp_count = 0; exp_err = 0;
        n_checks++;
        if ({McError, StallCount} !== '0) begin
            n_fail++; $display("FAIL rst_busy_regs McError=%b StallCount=%0d want 0/0", McError, StallCount);
        end
        rst = 0; quiet();
        @(negedge clk);
        n_checks++;
        if (outv !== 11'd0) begin n_fail++; $display("FAIL rst_busy_no_start got=%b want=0", outv); end
        tick(1'b0);
    endtask

    initial begin
        quiet();
        test_reset();
        test_load_use();
        test_branch();
        test_forwarding();
        test_multicycle(4, 1'b1);
        test_multicycle(TO, 1'b1);
        test_multicycle(TO + 3, 1'b0);
        test_multicycle(2, 1'b1);
        test_random_pipe(40);
        for (int i = 0; i < 6; i++) begin
            test_multicycle($urandom_range(1, 10), 1'($urandom_range(0, 1)));
            test_random_pipe(5);
        end
        test_reset_mid_busy();
        test_multicycle(1, 1'b1);
        test_multicycle(TO, 1'b0);
        test_multicycle(TO, 1'b0);
        test_random_pipe(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
